// File: rtl/calendar_pkg.sv
// calendar_pkg
// Shared encodings and date helpers for the calendar counter and anything
// else that compares dates (display, alarm).
//   SEL_*       : field-select encodings used by set mode
//   MONTH_*     : month numbers 1..12
//   is_leap     : Gregorian leap-year test
//   dim_of      : days in a given month of a given year
package calendar_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;

  typedef enum logic [1:0] {
    SEL_DAY   = 2'd0,
    SEL_MONTH = 2'd1,
    SEL_YEAR  = 2'd2,
    SEL_NONE  = 2'd3
  } sel_e;

  localparam logic [MONTH_W-1:0] MONTH_JAN = 4'd1;
  localparam logic [MONTH_W-1:0] MONTH_FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MONTH_MAR = 4'd3;
  localparam logic [MONTH_W-1:0] MONTH_APR = 4'd4;
  localparam logic [MONTH_W-1:0] MONTH_MAY = 4'd5;
  localparam logic [MONTH_W-1:0] MONTH_JUN = 4'd6;
  localparam logic [MONTH_W-1:0] MONTH_JUL = 4'd7;
  localparam logic [MONTH_W-1:0] MONTH_AUG = 4'd8;
  localparam logic [MONTH_W-1:0] MONTH_SEP = 4'd9;
  localparam logic [MONTH_W-1:0] MONTH_OCT = 4'd10;
  localparam logic [MONTH_W-1:0] MONTH_NOV = 4'd11;
  localparam logic [MONTH_W-1:0] MONTH_DEC = 4'd12;

  // Year is taken as 32 bits so callers of any year width can share it.
  function automatic logic is_leap(input logic [31:0] year);
    return (((year % 32'd4) == 32'd0) && ((year % 32'd100) != 32'd0)) ||
           ((year % 32'd400) == 32'd0);
  endfunction

  // Illegal month codes fall into the 31-day default; they are unreachable
  // from reset, so this only keeps the function total.
  function automatic logic [DAY_W-1:0] dim_of(input logic [31:0] year,
                                              input logic [MONTH_W-1:0] month);
    logic [DAY_W-1:0] d;
    case (month)
      MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: d = 5'd30;
      MONTH_FEB: d = is_leap(year) ? 5'd29 : 5'd28;
      default:   d = 5'd31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calendar_date_counter_days_in_month.sv
// days_in_month
// Combinational month-length lookup, shared with the display/alarm compare.
// Ports:
//   year  in  YEAR_W   calendar year
//   month in  MONTH_W  month 1..12
//   dim   out DAY_W    days in that month of that year
//   leap  out 1        year is a leap year
module days_in_month
  import calendar_pkg::*;
#(
  parameter int YEAR_W = 12
) (
  input  logic [YEAR_W-1:0]  year,
  input  logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   dim,
  output logic               leap
);

  always_comb begin
    leap = is_leap(32'(year));
    dim  = dim_of(32'(year), month);
  end

endmodule

// File: rtl/calendar_date_counter.sv
// calendar_date_counter
// Day/month/year counter advanced by a day-carry pulse, with manual set of
// each field and day clamping when month or year changes.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   tick_day         one-cycle day-carry pulse (ignored in set mode)
//   ctrl_set         set mode
//   sel, inc, dec    field select and edit strobes (set mode)
//   day/month/year   current date
//   leap, dim        combinational facts about the current date
//   carry_out        one-cycle pulse when a tick wraps MAX_YEAR to BASE_YEAR
module calendar_date_counter
  import calendar_pkg::*;
#(
  parameter int BASE_YEAR = 2025,
  parameter int MAX_YEAR  = 3025,
  parameter int YEAR_W    = 12,
  parameter int DEC_WRAP  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_day,
  input  logic               ctrl_set,
  input  logic [1:0]         sel,
  input  logic               inc,
  input  logic               dec,
  output logic [DAY_W-1:0]   day,
  output logic [MONTH_W-1:0] month,
  output logic [YEAR_W-1:0]  year,
  output logic               leap,
  output logic [DAY_W-1:0]   dim,
  output logic               carry_out
);

  localparam logic [YEAR_W-1:0] BASE_Y = YEAR_W'(BASE_YEAR);
  localparam logic [YEAR_W-1:0] MAX_Y  = YEAR_W'(MAX_YEAR);

  logic [DAY_W-1:0]   day_q, day_d, day_c, dim_c;
  logic [MONTH_W-1:0] month_q, month_d;
  logic [YEAR_W-1:0]  year_q, year_d;
  logic               carry_q, carry_d;
  sel_e               sel_s;

  assign sel_s = sel_e'(sel);

  days_in_month #(.YEAR_W(YEAR_W)) u_dim (
    .year  (year_q),
    .month (month_q),
    .dim   (dim),
    .leap  (leap)
  );

  always_comb begin
    day_c   = day_q;
    month_d = month_q;
    year_d  = year_q;
    carry_d = 1'b0;

    if (ctrl_set) begin
      if (inc || dec) begin
        case (sel_s)
          SEL_DAY: begin
            if (inc) day_c = (day_q >= dim) ? 5'd1 : day_q + 5'd1;
            else     day_c = (day_q <= 5'd1) ? dim : day_q - 5'd1;
          end
          SEL_MONTH: begin
            if (inc) month_d = (month_q == MONTH_DEC) ? MONTH_JAN : month_q + 4'd1;
            else     month_d = (month_q == MONTH_JAN) ? MONTH_DEC : month_q - 4'd1;
          end
          SEL_YEAR: begin
            if (inc)                  year_d = (year_q == MAX_Y) ? BASE_Y : year_q + YEAR_W'(1);
            else if (year_q != BASE_Y) year_d = year_q - YEAR_W'(1);
            else if (DEC_WRAP != 0)    year_d = MAX_Y;
            else                       year_d = BASE_Y;
          end
          default: ;
        endcase
      end
    end else if (tick_day) begin
      if (day_q < dim) begin
        day_c = day_q + 5'd1;
      end else begin
        day_c = 5'd1;
        if (month_q == MONTH_DEC) begin
          month_d = MONTH_JAN;
          if (year_q == MAX_Y) begin
            year_d  = BASE_Y;
            carry_d = 1'b1;
          end else begin
            year_d = year_q + YEAR_W'(1);
          end
        end else begin
          month_d = month_q + 4'd1;
        end
      end
    end

    // Clamp against the length of the month we are moving into, so a
    // month/year edit never leaves e.g. 31 April or 29 Feb in a common year.
    dim_c = dim_of(32'(year_d), month_d);
    day_d = (day_c > dim_c) ? dim_c : day_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q   <= 5'd1;
      month_q <= MONTH_JAN;
      year_q  <= BASE_Y;
      carry_q <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      carry_q <= carry_d;
    end
  end

  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// tb_calendar_date_counter
// Self-checking bench: directed scenarios plus a randomized run compared
// against a date model built from plain calendar arithmetic.
module tb_calendar_date_counter;

  localparam int BASE_YEAR = 2025;
  localparam int MAX_YEAR  = 3025;
  localparam int YEAR_W    = 12;
  localparam int DEC_WRAP  = 0;
  localparam int RANGE     = MAX_YEAR - BASE_YEAR + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              tick_day = 1'b0;
  logic              ctrl_set = 1'b0;
  logic [1:0]        sel = 2'd3;
  logic              inc = 1'b0;
  logic              dec = 1'b0;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic              leap;
  logic [4:0]        dim;
  logic              carry_out;

  int total = 0;
  int bad   = 0;

  int m_day, m_month, m_year, m_carry;

  calendar_date_counter #(
    .BASE_YEAR (BASE_YEAR),
    .MAX_YEAR  (MAX_YEAR),
    .YEAR_W    (YEAR_W),
    .DEC_WRAP  (DEC_WRAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_day  (tick_day),
    .ctrl_set  (ctrl_set),
    .sel       (sel),
    .inc       (inc),
    .dec       (dec),
    .day       (day),
    .month     (month),
    .year      (year),
    .leap      (leap),
    .dim       (dim),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  function automatic bit tb_leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int tb_dim(input int y, input int m);
    int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && tb_leap(y)) return 29;
    return len[m-1];
  endfunction

  function automatic logic [20:0] pack(input int d, input int m, input int y);
    return {5'(d), 4'(m), 12'(y)};
  endfunction

  // Calendar model: what one clock edge does to the date.
  task automatic model_step(input bit r, input bit t, input bit s,
                            input int sl, input bit i, input bit d);
    int n;
    int step;
    if (r) begin
      m_day = 1; m_month = 1; m_year = BASE_YEAR; m_carry = 0;
      return;
    end
    m_carry = 0;
    step = i ? 1 : -1;
    if (s) begin
      if (i || d) begin
        case (sl)
          0: begin
            n = tb_dim(m_year, m_month);
            m_day = ((m_day - 1 + step + n) % n) + 1;
          end
          1: m_month = ((m_month - 1 + step + 12) % 12) + 1;
          2: begin
            if (i)                     m_year = (m_year == MAX_YEAR) ? BASE_YEAR : m_year + 1;
            else if (m_year != BASE_YEAR) m_year = m_year - 1;
            else                       m_year = (DEC_WRAP != 0) ? MAX_YEAR : BASE_YEAR;
          end
          default: ;
        endcase
      end
    end else if (t) begin
      m_day++;
      if (m_day > tb_dim(m_year, m_month)) begin
        m_day = 1;
        m_month++;
        if (m_month > 12) begin
          m_month = 1;
          m_year++;
          if (m_year > MAX_YEAR) begin
            m_year  = BASE_YEAR;
            m_carry = 1;
          end
        end
      end
    end
    if (m_day > tb_dim(m_year, m_month)) m_day = tb_dim(m_year, m_month);
  endtask

  // Drive one cycle's inputs, advance the model, sample #1 after the edge.
  task automatic drive(input bit r, input bit t, input bit s,
                       input logic [1:0] sl, input bit i, input bit d);
    rst = r; tick_day = t; ctrl_set = s; sel = sl; inc = i; dec = d;
    model_step(r, t, s, int'(sl), i, d);
    @(posedge clk);
    #1;
    rst = 1'b0; tick_day = 1'b0; ctrl_set = 1'b0; sel = 2'd3; inc = 1'b0; dec = 1'b0;
  endtask

  // Walk to an arbitrary date through set-mode edits only.
  task automatic goto_date(input int d, input int m, input int y);
    int n;
    n = m_day - 1;                         repeat (n) drive(0, 0, 1, 2'd0, 0, 1);
    n = (y - m_year + RANGE) % RANGE;      repeat (n) drive(0, 0, 1, 2'd2, 1, 0);
    n = (m - m_month + 12) % 12;           repeat (n) drive(0, 0, 1, 2'd1, 1, 0);
    n = d - 1;                             repeat (n) drive(0, 0, 1, 2'd0, 1, 0);
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 2'd3, 0, 0);
    total++; if ({day, month, year} !== pack(1, 1, 2025)) begin bad++;
      $display("[TB] FAIL reset_date: got %0d/%0d/%0d want 1/1/2025", day, month, year); end
    total++; if (carry_out !== 1'b0) begin bad++;
      $display("[TB] FAIL reset_carry: got %b want 0", carry_out); end
    total++; if (leap !== 1'b0) begin bad++;
      $display("[TB] FAIL reset_leap: got %b want 0", leap); end
    total++; if (dim !== 5'd31) begin bad++;
      $display("[TB] FAIL reset_dim: got %0d want 31", dim); end
  endtask

  task automatic test_rollover;
    goto_date(30, 4, 2025);
    drive(0, 1, 0, 2'd3, 0, 0);
    total++; if ({day, month, year} !== pack(1, 5, 2025)) begin bad++;
      $display("[TB] FAIL rollover_apr: got %0d/%0d/%0d want 1/5/2025", day, month, year); end
    goto_date(31, 12, 2025);
    drive(0, 1, 0, 2'd3, 0, 0);
    total++; if ({day, month, year} !== pack(1, 1, 2026)) begin bad++;
      $display("[TB] FAIL rollover_dec: got %0d/%0d/%0d want 1/1/2026", day, month, year); end
    total++; if (carry_out !== 1'b0) begin bad++;
      $display("[TB] FAIL rollover_carry: got %b want 0", carry_out); end
  endtask

  task automatic test_leap;
    goto_date(28, 2, 2028);
    drive(0, 1, 0, 2'd3, 0, 0);
    total++; if ({day, month, year} !== pack(29, 2, 2028)) begin bad++;
      $display("[TB] FAIL leap_2028_29: got %0d/%0d/%0d want 29/2/2028", day, month, year); end
    total++; if (dim !== 5'd29) begin bad++;
      $display("[TB] FAIL leap_2028_dim: got %0d want 29", dim); end
    drive(0, 1, 0, 2'd3, 0, 0);
    total++; if ({day, month, year} !== pack(1, 3, 2028)) begin bad++;
      $display("[TB] FAIL leap_2028_mar: got %0d/%0d/%0d want 1/3/2028", day, month, year); end
    goto_date(28, 2, 2100);
    drive(0, 1, 0, 2'd3, 0, 0);
    total++; if ({day, month, year, leap} !== {pack(1, 3, 2100), 1'b0}) begin bad++;
      $display("[TB] FAIL leap_2100: got %0d/%0d/%0d leap=%b want 1/3/2100 leap=0", day, month, year, leap); end
    goto_date(28, 2, 2400);
    drive(0, 1, 0, 2'd3, 0, 0);
    total++; if ({day, month, year, leap} !== {pack(29, 2, 2400), 1'b1}) begin bad++;
      $display("[TB] FAIL leap_2400: got %0d/%0d/%0d leap=%b want 29/2/2400 leap=1", day, month, year, leap); end
  endtask

  task automatic test_wrap;
    goto_date(31, 12, 3025);
    drive(0, 1, 0, 2'd3, 0, 0);
    total++; if ({day, month, year} !== pack(1, 1, 2025)) begin bad++;
      $display("[TB] FAIL wrap_date: got %0d/%0d/%0d want 1/1/2025", day, month, year); end
    total++; if (carry_out !== 1'b1) begin bad++;
      $display("[TB] FAIL wrap_carry_high: got %b want 1", carry_out); end
    drive(0, 0, 0, 2'd3, 0, 0);
    total++; if (carry_out !== 1'b0) begin bad++;
      $display("[TB] FAIL wrap_carry_low: got %b want 0", carry_out); end
    goto_date(5, 5, 3025);
    drive(0, 0, 1, 2'd2, 1, 0);
    total++; if ({day, month, year, carry_out} !== {pack(5, 5, 2025), 1'b0}) begin bad++;
      $display("[TB] FAIL set_year_wrap: got %0d/%0d/%0d carry=%b want 5/5/2025 carry=0", day, month, year, carry_out); end
  endtask

  task automatic test_set_mode;
    int exp_y;
    goto_date(15, 6, 2025);
    drive(0, 0, 1, 2'd2, 0, 1);
    exp_y = (DEC_WRAP != 0) ? MAX_YEAR : BASE_YEAR;
    total++; if (int'(year) !== exp_y) begin bad++;
      $display("[TB] FAIL set_year_dec_base: got %0d want %0d", year, exp_y); end
    goto_date(15, 6, 2025);
    drive(0, 1, 1, 2'd1, 1, 0);
    total++; if ({day, month, year} !== pack(15, 7, 2025)) begin bad++;
      $display("[TB] FAIL set_ignores_tick: got %0d/%0d/%0d want 15/7/2025", day, month, year); end
    goto_date(1, 4, 2025);
    drive(0, 0, 1, 2'd0, 0, 1);
    total++; if ({day, month, year} !== pack(30, 4, 2025)) begin bad++;
      $display("[TB] FAIL set_day_dec_wrap: got %0d/%0d/%0d want 30/4/2025", day, month, year); end
    drive(0, 0, 1, 2'd0, 1, 1);
    total++; if ({day, month, year} !== pack(1, 4, 2025)) begin bad++;
      $display("[TB] FAIL set_inc_over_dec: got %0d/%0d/%0d want 1/4/2025", day, month, year); end
    drive(0, 1, 1, 2'd3, 1, 0);
    total++; if ({day, month, year} !== pack(1, 4, 2025)) begin bad++;
      $display("[TB] FAIL set_sel_none: got %0d/%0d/%0d want 1/4/2025", day, month, year); end
  endtask

  task automatic test_clamp;
    goto_date(31, 3, 2025);
    drive(0, 0, 1, 2'd1, 1, 0);
    total++; if ({day, month, year} !== pack(30, 4, 2025)) begin bad++;
      $display("[TB] FAIL clamp_month: got %0d/%0d/%0d want 30/4/2025", day, month, year); end
    goto_date(29, 2, 2028);
    drive(0, 0, 1, 2'd2, 1, 0);
    total++; if ({day, month, year} !== pack(28, 2, 2029)) begin bad++;
      $display("[TB] FAIL clamp_year_inc: got %0d/%0d/%0d want 28/2/2029", day, month, year); end
    goto_date(29, 2, 2028);
    drive(0, 0, 1, 2'd2, 0, 1);
    total++; if ({day, month, year} !== pack(28, 2, 2027)) begin bad++;
      $display("[TB] FAIL clamp_year_dec: got %0d/%0d/%0d want 28/2/2027", day, month, year); end
    drive(1, 0, 1, 2'd2, 1, 0);
    total++; if ({day, month, year} !== pack(1, 1, 2025)) begin bad++;
      $display("[TB] FAIL reset_mid_set: got %0d/%0d/%0d want 1/1/2025", day, month, year); end
  endtask

  task automatic test_random;
    bit r, t, s, i, d;
    logic [1:0] sl;
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 1) == 1);
      sl = 2'($urandom_range(0, 3));
      i  = ($urandom_range(0, 1) == 1);
      d  = ($urandom_range(0, 1) == 1);
      drive(r, t, s, sl, i, d);
      total++; if ({day, month, year} !== pack(m_day, m_month, m_year)) begin bad++;
        $display("[TB] FAIL rand_date[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", k, day, month, year, m_day, m_month, m_year); end
      total++; if (carry_out !== 1'(m_carry)) begin bad++;
        $display("[TB] FAIL rand_carry[%0d]: got %b want %0d", k, carry_out, m_carry); end
      total++; if (leap !== tb_leap(m_year)) begin bad++;
        $display("[TB] FAIL rand_leap[%0d]: got %b want %b", k, leap, tb_leap(m_year)); end
      total++; if (int'(dim) !== tb_dim(m_year, m_month)) begin bad++;
        $display("[TB] FAIL rand_dim[%0d]: got %0d want %0d", k, dim, tb_dim(m_year, m_month)); end
    end
  endtask

  initial begin
    m_day = 1; m_month = 1; m_year = BASE_YEAR; m_carry = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_rollover();
    test_leap();
    test_wrap();
    test_set_mode();
    test_clamp();
    drive(1, 0, 0, 2'd3, 0, 0);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
Parametrised day/month/year calendar counter and the successor to the standalone year counter. It advances the date on a day-carry pulse from the time-of-day chain and handles leap years and month lengths. It supports manual set of any field, and clamps the day when the month or year changes. It feeds the date display and the millennium-wrap logic.

Parameters:
BASE_YEAR, 2025, year loaded at reset and after wrap; lowest settable year
MAX_YEAR, 3025, highest year; must exceed BASE_YEAR
YEAR_W, 12, year field width; must hold MAX_YEAR
DEC_WRAP, 0, 0 = year dec saturates at BASE_YEAR; 1 = year dec wraps BASE_YEAR->MAX_YEAR

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick_day  in  1  one-cycle day-carry pulse from hour counter
ctrl_set  in  1  set mode; when high, ticks are ignored
sel  in  2  field select in set mode: 0 day, 1 month, 2 year, 3 none
inc  in  1  increment selected field (set mode only)
dec  in  1  decrement selected field (set mode only)
day  out  5  day of month, 1..31
month  out  4  month, 1..12
year  out  YEAR_W  year, BASE_YEAR..MAX_YEAR
leap  out  1  combinational: current year is a leap year
dim  out  5  combinational: days in current month/year
carry_out  out  1  registered one-cycle pulse on MAX_YEAR->BASE_YEAR wrap by tick

Behaviour:
- Reset (rst high at clk edge): day=1, month=1, year=BASE_YEAR, carry_out=0. Reset overrides all other inputs.
- All state updates on the rising clk edge. Latency is 1 cycle from an input to the output change.
- Priority: rst > ctrl_set > tick_day.
- Leap rule: (year%4==0 && year%100!=0) || year%400==0.
- dim: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for Feb if leap, else 28.
- Run mode (ctrl_set=0, tick_day=1):
  - day<dim: day+1.
  - day==dim: day=1 and month+1.
  - Month 12 rolls to 1 and year+1.
  - Year MAX_YEAR with a Dec 31 tick: year=BASE_YEAR, and carry_out=1 for exactly one cycle.
- Set mode (ctrl_set=1):
  - tick_day is ignored and dropped, not queued.
  - inc has priority over dec when both are high.
  - sel=3 or no inc/dec: hold.
  - Day: inc dim->1, dec 1->dim. No carry into month.
  - Month: inc 12->1, dec 1->12. No carry into year.
  - Year: inc MAX_YEAR->BASE_YEAR. Dec at BASE_YEAR holds if DEC_WRAP=0, or goes to MAX_YEAR if DEC_WRAP=1.
  - Year edits in set mode never assert carry_out.
- Clamp: any month or year change (set or run) that would leave day > new dim sets day=dim in the same cycle. Example: Feb 29 2028, year dec -> Feb 28 2027.
- carry_out is 0 in every cycle other than the tick-driven wrap cycle.
- Toggling ctrl_set mid-sequence has no side effects; the next edge uses the new mode.
- Outputs never leave the legal ranges. After reset the only reachable states are valid dates.

Decomposition:
- Package calendar_pkg holds:
  - SEL_DAY/SEL_MONTH/SEL_YEAR/SEL_NONE encodings
  - MONTH_JAN..MONTH_DEC constants
  - DAY_W=5, MONTH_W=4
- Sub-module days_in_month (combinational: year, month -> dim, leap), shared with the display/alarm date compare.

Test Plan:
- Reset: rst=1 for 1 cycle -> 1/1/2025, carry_out=0, leap=0, dim=31.
- Month-end rollover: from 30/4/2025, one tick -> 1/5/2025. From 31/12/2025, one tick -> 1/1/2026.
- Leap cases: from 28/2/2028, tick -> 29/2/2028, tick -> 1/3/2028. From 28/2/2100, tick -> 1/3/2100 (leap=0). From 28/2/2400, tick -> 29/2/2400 (leap=1).
- Millennium wrap: from 31/12/3025, tick -> 1/1/2025, with carry_out high for exactly one cycle then low.
- Set mode: sel=2, dec at 2025 -> holds 2025 (DEC_WRAP=0) or goes to 3025 (DEC_WRAP=1). With tick_day and inc both high, only the set-mode edit applies. With sel=0, dec from day 1 in April -> 30, month unchanged.
- Clamp: at 31/3/2025, sel=1 inc -> 30/4/2025. At 29/2/2028, sel=2 inc -> 28/2/2029. Reset asserted mid-set -> 1/1/2025 next edge.
